ripple_carry_adder: RTL and testbench
=====================================

// Module: ripple_carry_adder
//
// PURPOSE
// - WIDTH-bit ripple-carry adder with carry-in/carry-out: sum = a + b + cin.
// - Datapath arithmetic leaf built from a chain of 1-bit full-adder cells.
// - Result registered once on the clock, so it can sit directly in pipelined datapaths.
// - Signed-overflow flag provided for two's-complement users.
//
// PARAMETERS
// - WIDTH  4  operand/sum width in bits; legal range 1..64
//
// PORTS
// - clk       in   1      single clock; all state updates on rising edge
// - rst       in   1      asynchronous, active-high reset
// - in_valid  in   1      a/b/cin qualify this cycle
// - a         in   WIDTH  operand A, unsigned or two's complement
// - b         in   WIDTH  operand B
// - cin       in   1      carry-in, weight 1
// - out_valid out  1      sum/cout/ovf hold the result of an accepted operation
// - sum       out  WIDTH  low WIDTH bits of a+b+cin
// - cout      out  1      carry out of bit WIDTH-1 (unsigned overflow)
// - ovf       out  1      signed overflow: carry into MSB XOR carry out of MSB
//
// BEHAVIOUR
// - Clocking and reset: one clock domain. rst asserted, asynchronously ->
//   out_valid=0, sum=0, cout=0, ovf=0. Release is synchronous to clk.
// - Combinational core:
//   - c[0]=cin.
//   - For each bit i: s[i]=a[i]^b[i]^c[i] and c[i+1]=(a[i]&b[i])|(c[i]&(a[i]^b[i])).
//   - cout=c[WIDTH], ovf=c[WIDTH]^c[WIDTH-1].
// - Latency: exactly 1 cycle.
//   - On a rising edge with in_valid=1, the core result is loaded into sum/cout/ovf
//     and out_valid=1 for the next cycle.
//   - On a rising edge with in_valid=0, out_valid drops to 0 and sum/cout/ovf hold
//     their previous values.
// - Handshake: no backpressure. A new operation is accepted every cycle that
//   in_valid=1 (full throughput).
// - Wrap-around: the result is modulo 2^WIDTH. Overflow is reported only via
//   cout/ovf and is never saturated.
// - Boundary cases:
//   - all-ones + 0 + cin=1 -> sum=0, cout=1.
//   - WIDTH=1 degenerates to a single registered full adder.
// - Reset mid-operation: an in-flight result is discarded and outputs read 0.
//   The first result after release appears one cycle after the first accepted
//   in_valid.
// - X-free: with no valid input since reset, outputs stay at their reset values.
//
// STRUCTURE
// - Sub-module full_adder_cell (a, b, ci -> s, co), instantiated WIDTH times
//   via generate.
// - Top level holds only the carry chain wiring, the ovf XOR and the output registers.
// - No shared package is needed. WIDTH is a local parameter of this module only.
//
// TESTING
// - Each vector: in_valid=1 for one cycle, check outputs one cycle later.
// - T1: a=0000 b=0000 cin=0 -> sum=0000 cout=0 ovf=0.
// - T2: a=0011 b=0101 cin=0 -> sum=1000 cout=0 ovf=1.
// - T3: a=1111 b=0001 cin=0 -> sum=0000 cout=1 ovf=0.
// - T4: a=1010 b=0110 cin=1 -> sum=0001 cout=1 ovf=0.
// - T5: back-to-back T1..T4 on consecutive cycles -> results on consecutive
//   cycles, out_valid held at 1. Then drop in_valid -> out_valid=0, sum holds 0001.
// - T6: assert rst asynchronously between edges with out_valid=1 ->
//   all outputs 0 immediately. After release, exhaustive 4-bit a/b/cin sweep
//   matches the a+b+cin reference.

Source files
------------

// File: rtl/ripple_carry_adder_fa.sv
// full_adder_cell: one-bit full adder, purely combinational (0 cycles).
// No state, no handshake; one cell per bit of the ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder with carry/overflow flags; result registered, 1-cycle latency.
// No backpressure: every cycle with in_valid=1 is accepted; idle cycles hold the last result.
module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] s_w;
  logic             carry_out_w;
  logic             carry_msb_w;

  // Per-bit carry nets live in their own generate scope so the chain is not one self-feeding vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic ci_w;
    logic co_w;

    if (i == 0) begin : g_first
      assign ci_w = cin;
    end else begin : g_rest
      assign ci_w = g_bit[i-1].co_w;
    end

    full_adder_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (ci_w),
      .s  (s_w[i]),
      .co (co_w)
    );
  end

  assign carry_out_w = g_bit[WIDTH-1].co_w;
  assign carry_msb_w = g_bit[WIDTH-1].ci_w;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    out_valid_d = in_valid;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (in_valid) begin
      sum_d  = s_w;
      cout_d = carry_out_w;
      ovf_d  = carry_out_w ^ carry_msb_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Bench for ripple_carry_adder: directed vector table, pipelined back-to-back, async reset,
// exhaustive sweep and random traffic checked against an integer-arithmetic model.
module tb_ripple_carry_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout, ovf;

  always #5 clk = ~clk;

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t tbl [4];

  int total = 0;
  int bad   = 0;

  // Model state: what the outputs should show after the next edge.
  logic         m_vld;
  logic [W-1:0] m_sum;
  logic         m_cout;
  logic         m_ovf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference computed from plain unsigned and signed integer sums.
  task automatic model_add(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                           output logic [W-1:0] rs, output logic rc, output logic ro);
    int u, sa, sb, s;
    u  = int'(ia) + int'(ib) + int'(ic);
    sa = int'(ia);
    sb = int'(ib);
    if (ia[W-1]) sa = sa - (1 << W);
    if (ib[W-1]) sb = sb - (1 << W);
    s  = sa + sb + int'(ic);
    rs = u[W-1:0];
    rc = (u >= (1 << W));
    ro = (s > ((1 << (W-1)) - 1)) || (s < -(1 << (W-1)));
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_vld));
    chk({tag, ".sum"},       64'(sum),       64'(m_sum));
    chk({tag, ".cout"},      64'(cout),      64'(m_cout));
    chk({tag, ".ovf"},       64'(ovf),       64'(m_ovf));
  endtask

  // Called just after a falling edge: drive, update model, wait one cycle, compare.
  task automatic step(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic ic, input string tag);
    logic [W-1:0] rs;
    logic         rc, ro;
    in_valid = v;
    a        = ia;
    b        = ib;
    cin      = ic;
    model_add(ia, ib, ic, rs, rc, ro);
    m_vld = v;
    if (v) begin
      m_sum  = rs;
      m_cout = rc;
      m_ovf  = ro;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_sum  = '0;
    m_cout = 1'b0;
    m_ovf  = 1'b0;
  endtask

  initial begin
    tbl[0] = '{a: 4'b0000, b: 4'b0000, cin: 1'b0, sum: 4'b0000, cout: 1'b0, ovf: 1'b0};
    tbl[1] = '{a: 4'b0011, b: 4'b0101, cin: 1'b0, sum: 4'b1000, cout: 1'b0, ovf: 1'b1};
    tbl[2] = '{a: 4'b1111, b: 4'b0001, cin: 1'b0, sum: 4'b0000, cout: 1'b1, ovf: 1'b0};
    tbl[3] = '{a: 4'b1010, b: 4'b0110, cin: 1'b1, sum: 4'b0001, cout: 1'b1, ovf: 1'b0};

    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;

    // No valid input since reset: outputs must stay at reset values.
    step(1'b0, 4'hF, 4'hF, 1'b1, "idle");
    step(1'b0, 4'h5, 4'hA, 1'b0, "idle2");

    // T1..T4 from the fixed table, one operation at a time.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a        = tbl[i].a;
      b        = tbl[i].b;
      cin      = tbl[i].cin;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("T%0d.out_valid", i + 1), 64'(out_valid), 64'd1);
      chk($sformatf("T%0d.sum", i + 1),       64'(sum),       64'(tbl[i].sum));
      chk($sformatf("T%0d.cout", i + 1),      64'(cout),      64'(tbl[i].cout));
      chk($sformatf("T%0d.ovf", i + 1),       64'(ovf),       64'(tbl[i].ovf));
      @(negedge clk);
      chk($sformatf("T%0d.drop", i + 1), 64'(out_valid), 64'd0);
    end

    // T5: back-to-back, results on consecutive cycles.
    in_valid = 1'b1;
    a        = tbl[0].a;
    b        = tbl[0].b;
    cin      = tbl[0].cin;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("T5[%0d].out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("T5[%0d].sum", i),       64'(sum),       64'(tbl[i].sum));
      chk($sformatf("T5[%0d].cout", i),      64'(cout),      64'(tbl[i].cout));
      chk($sformatf("T5[%0d].ovf", i),       64'(ovf),       64'(tbl[i].ovf));
      if (i < 3) begin
        a   = tbl[i+1].a;
        b   = tbl[i+1].b;
        cin = tbl[i+1].cin;
      end else begin
        in_valid = 1'b0;
        a        = 4'hC;
        b        = 4'h7;
      end
    end
    @(negedge clk);
    chk("T5.drop.out_valid", 64'(out_valid), 64'd0);
    chk("T5.hold.sum",       64'(sum),       64'b0001);
    chk("T5.hold.cout",      64'(cout),      64'd1);

    // T6: asynchronous reset between edges while a result is showing.
    in_valid = 1'b1;
    a        = 4'b0111;
    b        = 4'b0111;
    cin      = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("T6.pre.out_valid", 64'(out_valid), 64'd1);
    chk("T6.pre.sum",       64'(sum),       64'hF);
    #2;
    rst = 1'b1;
    #1;
    chk("T6.async.out_valid", 64'(out_valid), 64'd0);
    chk("T6.async.sum",       64'(sum),       64'd0);
    chk("T6.async.cout",      64'(cout),      64'd0);
    chk("T6.async.ovf",       64'(ovf),       64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Exhaustive a/b/cin sweep, fully pipelined.
    for (int ia = 0; ia < (1 << W); ia++)
      for (int ib = 0; ib < (1 << W); ib++)
        for (int ic = 0; ic < 2; ic++)
          step(1'b1, W'(ia), W'(ib), ic[0], "sweep");

    // Random traffic with random idle cycles.
    for (int n = 0; n < 400; n++)
      step(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom), "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the whole run is a bounded number of cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
